// File: rtl/output_port_allocator_if.sv
// Bundle of the input-side request/flit lines, the published occupied word
// and the downstream output link for one router output port.
`ifndef FLIT_SIZE
`define FLIT_SIZE 32
`endif

// Handshake rules:
// - On the input side, a flit from input i moves when in_valid[i] and in_ready[i]
//   are both 1 at a rising clock edge.
// - On the output side, a flit moves when out_valid and out_ready are both 1 at a
//   rising clock edge.
// - While out_valid=1 and out_ready=0, out_flit and out_tail hold steady.
interface output_port_allocator_if #(
  parameter int NUM_IN = 5,
  parameter int FLIT_W = `FLIT_SIZE
);
  logic [NUM_IN-1:0]        in_req;
  logic [NUM_IN-1:0]        in_valid;
  logic [NUM_IN-1:0]        in_tail;
  logic [NUM_IN*FLIT_W-1:0] in_flit;
  logic [NUM_IN-1:0]        in_ready;
  logic [0:3]               occupied;
  logic                     out_valid;
  logic [FLIT_W-1:0]        out_flit;
  logic                     out_tail;
  logic                     out_ready;

  // The allocator side.
  modport slave (
    input  in_req, in_valid, in_tail, in_flit, out_ready,
    output in_ready, occupied, out_valid, out_flit, out_tail
  );

  // The side that drives the inputs and consumes the output link.
  modport master (
    output in_req, in_valid, in_tail, in_flit, out_ready,
    input  in_ready, occupied, out_valid, out_flit, out_tail
  );
endinterface

// File: rtl/output_port_allocator.sv
// Output port allocator: round-robin grant among requesting inputs, the port
// stays locked to the winner until its tail flit, and flits are forwarded
// through a one-entry output register.
`ifndef FLIT_SIZE
`define FLIT_SIZE 32
`endif

module output_port_allocator #(
  parameter int         NUM_IN  = 5,
  parameter int         FLIT_W  = `FLIT_SIZE,
  parameter logic [2:0] PORT_ID = 3'd0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output_port_allocator_if.slave bus,
  output logic                   o_dbg_busy,
  output logic [2:0]             o_dbg_rr_ptr,
  output logic [2:0]             o_port_id
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_owner;
  logic [2:0]        r_rr_ptr;
  logic              r_out_valid;
  logic [FLIT_W-1:0] r_out_flit;
  logic              r_out_tail;

  logic              w_found;
  logic [2:0]        w_winner;
  logic [3:0]        w_idx;
  logic              w_own_valid;
  logic              w_own_tail;
  logic [FLIT_W-1:0] w_own_flit;
  logic              w_out_space;
  logic              w_xfer;
  logic              w_release;
  logic [2:0]        w_rr_next;

  // Round-robin scan starting at r_rr_ptr and wrapping past NUM_IN-1.
  always_comb begin
    w_found  = 1'b0;
    w_winner = 3'd0;
    w_idx    = 4'd0;
    for (int k = 0; k < NUM_IN; k++) begin
      w_idx = {1'b0, r_rr_ptr} + 4'(k);
      if (w_idx >= 4'(NUM_IN)) w_idx = w_idx - 4'(NUM_IN);
      for (int i = 0; i < NUM_IN; i++) begin
        if (!w_found && (w_idx == 4'(i)) && bus.in_req[i]) begin
          w_found  = 1'b1;
          w_winner = 3'(i);
        end
      end
    end
  end

  // Select the owner's valid, tail and flit lines.
  always_comb begin
    w_own_valid = 1'b0;
    w_own_tail  = 1'b0;
    w_own_flit  = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (r_owner == 3'(i)) begin
        w_own_valid = bus.in_valid[i];
        w_own_tail  = bus.in_tail[i];
        w_own_flit  = bus.in_flit[i*FLIT_W +: FLIT_W];
      end
    end
  end

  // The output register can take a flit if it is empty or being drained now.
  assign w_out_space = ~r_out_valid | bus.out_ready;
  assign w_xfer      = (r_state == S_BUSY) & w_own_valid & w_out_space;
  assign w_release   = w_xfer & w_own_tail;
  assign w_rr_next   = (r_owner == 3'(NUM_IN-1)) ? 3'd0 : r_owner + 3'd1;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: grant on any request in IDLE, release on an accepted tail.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found)   w_state_nxt = S_BUSY;
      S_BUSY:  if (w_release) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Only the owner sees ready, and only while the port is locked.
  always_comb begin
    bus.in_ready = '0;
    if (r_state == S_BUSY) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (r_owner == 3'(i)) bus.in_ready[i] = w_out_space;
      end
    end
    // The owner id is cleared on release, so the word is all-zero when idle.
    bus.occupied = {(r_state == S_BUSY), r_owner};
  end

  // Owner latch on grant, and the pointer advances past the owner on release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_owner  <= 3'd0;
      r_rr_ptr <= 3'd0;
    end else if ((r_state == S_IDLE) && w_found) begin
      r_owner <= w_winner;
    end else if (w_release) begin
      r_owner  <= 3'd0;
      r_rr_ptr <= w_rr_next;
    end
  end

  // One-entry output register; a load and a drain in the same cycle keep the
  // link at one flit per cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_flit  <= '0;
      r_out_tail  <= 1'b0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_flit  <= w_own_flit;
      r_out_tail  <= w_own_tail;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_flit  = r_out_flit;
  assign bus.out_tail  = r_out_tail;
  assign o_dbg_busy    = (r_state == S_BUSY);
  assign o_dbg_rr_ptr  = r_rr_ptr;
  assign o_port_id     = PORT_ID;

endmodule

// File: tb/tb_output_port_allocator.sv
// Bench for output_port_allocator: directed scenarios followed by random
// traffic, all checked against a packet/queue-level reference model.
module tb_output_port_allocator;
  localparam int N = 5;
  localparam int W = 16;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  output_port_allocator_if #(.NUM_IN(N), .FLIT_W(W)) bus();
  logic       dbg_busy;
  logic [2:0] dbg_rr;
  logic [2:0] port_id;

  output_port_allocator #(.NUM_IN(N), .FLIT_W(W), .PORT_ID(3'd2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .o_dbg_busy   (dbg_busy),
    .o_dbg_rr_ptr (dbg_rr),
    .o_port_id    (port_id)
  );

  // reference model: lock status plus the queue of flits the link still owes
  bit           m_busy;
  logic [2:0]   m_owner;
  logic [2:0]   m_rr;
  logic [W:0]   exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 3'd0;
    m_rr    = 3'd0;
    exp_q.delete();
  endtask

  // One clock cycle: drive, check the pre-edge outputs, advance the model.
  task automatic step(input logic [N-1:0] req, input logic [N-1:0] valid,
                      input logic [N-1:0] tail, input logic ordy, input logic rst);
    logic [N-1:0] exp_rdy;
    logic [3:0]   exp_occ;
    logic [W-1:0] own_flit;
    bit           space;
    int           idx;
    bit           found;
    @(negedge clk);
    rst_n         = rst;
    bus.in_req    = req;
    bus.in_valid  = valid;
    bus.in_tail   = tail;
    bus.out_ready = ordy;
    for (int i = 0; i < N; i++) bus.in_flit[i*W +: W] = W'($urandom);
    #1;
    space   = (exp_q.size() == 0) || ordy;
    exp_rdy = (m_busy && space) ? (N'(1) << m_owner) : '0;
    exp_occ = m_busy ? {1'b1, m_owner} : 4'b0000;
    check("occupied", 32'(bus.occupied), 32'(exp_occ));
    check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) check("out_flit", 32'({bus.out_tail, bus.out_flit}), 32'(exp_q[0]));
    check("rr_ptr", 32'(dbg_rr), 32'(m_rr));
    check("busy_dbg", 32'(dbg_busy), 32'(m_busy));
    own_flit = '0;
    for (int i = 0; i < N; i++) if (3'(i) == m_owner) own_flit = bus.in_flit[i*W +: W];
    if (!rst) begin
      model_reset();
    end else begin
      if (ordy && exp_q.size() > 0) void'(exp_q.pop_front());
      if (m_busy) begin
        if (space && valid[m_owner]) begin
          exp_q.push_back({tail[m_owner], own_flit});
          if (tail[m_owner]) begin
            m_busy = 1'b0;
            m_rr   = 3'((int'(m_owner) + 1) % N);
          end
        end
      end else begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          idx = (int'(m_rr) + k) % N;
          if (!found && req[3'(idx)]) begin
            found   = 1'b1;
            m_busy  = 1'b1;
            m_owner = 3'(idx);
          end
        end
      end
    end
  endtask

  initial begin
    bus.in_req = '0; bus.in_valid = '0; bus.in_tail = '0; bus.in_flit = '0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    check("rst_occupied", 32'(bus.occupied), 32'h0);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_out_flit", 32'(bus.out_flit), 32'h0);
    check("rst_out_tail", 32'(bus.out_tail), 32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'h0);
    check("rst_rr", 32'(dbg_rr), 32'h0);

    // single requester, 3-flit packet streaming at full rate
    step(5'b00100, 5'b00000, 5'b00000, 1, 1);
    step(5'b00000, 5'b00100, 5'b00000, 1, 1);
    check("grant_in2", 32'(bus.occupied), 32'b1010);
    step(5'b00000, 5'b00100, 5'b00000, 1, 1);
    step(5'b00000, 5'b00100, 5'b00100, 1, 1);
    step(5'b00000, 5'b00000, 5'b00000, 1, 1);
    check("release_occ", 32'(bus.occupied), 32'h0);
    check("rr_after_in2", 32'(dbg_rr), 32'd3);

    // contention from rr_ptr=0
    step(5'b00000, 5'b00000, 5'b00000, 1, 0);
    step(5'b10010, 5'b00000, 5'b00000, 1, 1);
    step(5'b10000, 5'b00010, 5'b00000, 1, 1);
    check("contend_in1", 32'(bus.occupied), 32'b1001);
    step(5'b10000, 5'b00010, 5'b00010, 1, 1);
    step(5'b10000, 5'b00000, 5'b00000, 1, 1);
    step(5'b00000, 5'b10000, 5'b10000, 1, 1);
    check("contend_in4", 32'(bus.occupied), 32'b1100);
    step(5'b00000, 5'b00000, 5'b00000, 1, 1);
    check("rr_wrap", 32'(dbg_rr), 32'd0);

    // backpressure: output held for 4 cycles, then full rate
    step(5'b00001, 5'b00000, 5'b00000, 1, 1);
    step(5'b00000, 5'b00001, 5'b00000, 1, 1);
    repeat (4) step(5'b00000, 5'b00001, 5'b00000, 0, 1);
    check("bp_in_ready", 32'(bus.in_ready), 32'h0);
    step(5'b00000, 5'b00001, 5'b00000, 1, 1);
    step(5'b00000, 5'b00001, 5'b00000, 1, 1);
    step(5'b00000, 5'b00001, 5'b00001, 1, 1);
    step(5'b00000, 5'b00000, 5'b00000, 1, 1);

    // single-flit packet
    step(5'b00100, 5'b00000, 5'b00000, 1, 1);
    step(5'b00000, 5'b00100, 5'b00100, 1, 1);
    step(5'b00000, 5'b00000, 5'b00000, 1, 1);
    check("single_flit_idle", 32'(bus.occupied), 32'h0);

    // non-owner isolation: input 3 keeps pushing while input 0 owns the port
    step(5'b00001, 5'b00000, 5'b00000, 1, 1);
    step(5'b01000, 5'b01001, 5'b00000, 1, 1);
    step(5'b01000, 5'b01001, 5'b00000, 0, 1);
    step(5'b01000, 5'b01001, 5'b01001, 1, 1);
    step(5'b00000, 5'b00000, 5'b00000, 1, 1);

    // reset in the middle of a 4-flit packet
    step(5'b00010, 5'b00000, 5'b00000, 1, 1);
    step(5'b00000, 5'b00010, 5'b00000, 1, 1);
    step(5'b00000, 5'b00010, 5'b00000, 1, 1);
    step(5'b00000, 5'b00010, 5'b00000, 1, 0);
    step(5'b00000, 5'b00000, 5'b00000, 1, 1);
    check("midrst_occ", 32'(bus.occupied), 32'h0);
    check("midrst_out_valid", 32'(bus.out_valid), 32'h0);
    check("midrst_rr", 32'(dbg_rr), 32'h0);
    step(5'b00100, 5'b00000, 5'b00000, 1, 1);
    step(5'b00000, 5'b00000, 5'b00000, 1, 1);
    check("midrst_regrant", 32'(bus.occupied), 32'b1010);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      step(N'($urandom), N'($urandom), N'($urandom & $urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 199) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/output_port_allocator.md
Name: output_port_allocator

Overview:
- Output-side counterpart of the per-input priority logic in the NoC router.
- Owns one router output port: arbitrates among input ports requesting it (round-robin), locks the output to the winner for a whole packet, forwards its flits through a one-entry output register with valid/ready handshake, and releases on the tail flit.
- Publishes the `occupied` status word that the input-side priority logic consumes: bit 0 = busy, bits 1:3 = owning input id.

Parameters:
- NUM_IN, 5, number of input ports competing for this output (1..8; owner id is 3 bits).
- FLIT_W, `FLIT_SIZE, flit width in bits.
- PORT_ID, 3'd0, id of this output port; informational, no effect on behaviour.

Ports:
- clk  input  1  router clock; all state changes on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_req  input  NUM_IN  bit i = input i has a head flit routed to this output (route compare already done).
- in_valid  input  NUM_IN  bit i = input i presents a valid flit.
- in_tail  input  NUM_IN  bit i = input i's presented flit is a tail (head-and-tail = single-flit packet).
- in_flit  input  NUM_IN*FLIT_W  flattened flits; input i occupies bits [i*FLIT_W +: FLIT_W].
- in_ready  output  NUM_IN  bit i = flit from input i accepted this cycle (when in_valid[i]=1).
- occupied  output  [0:3]  [0] busy, [1:3] owner input id; matches the `occupied` input format of the priority logic.
- out_valid  output  1  output register holds a flit.
- out_flit  output  FLIT_W  registered flit to link/crossbar.
- out_tail  output  1  registered tail marker.
- out_ready  input  1  downstream accepts the flit this cycle.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE, occupied=4'b0000, rr_ptr=0, out_valid=0, out_flit=0, out_tail=0.
  - in_ready=0 (combinational, forced low while state is IDLE).
  - Any in-flight packet is dropped; no partial release handshake.
- States:
  - IDLE: occupied[0]=0.
    - If in_req is nonzero: pick the first set bit scanning rr_ptr, rr_ptr+1, …, NUM_IN-1, 0, …, rr_ptr-1.
    - Next cycle: owner=winner, occupied={1,owner}, state=BUSY.
    - If in_req is zero: stay IDLE.
    - No flit is accepted in IDLE, so grant latency is 1 cycle from request.
  - BUSY: in_ready[owner] = out_space, where out_space = ~out_valid | out_ready. All other in_ready bits are 0.
    - Transfer when in_valid[owner] & in_ready[owner]: out_flit<=in_flit[owner], out_tail<=in_tail[owner], out_valid<=1.
    - If the transferred flit has in_tail=1: next state=IDLE, occupied<=0, rr_ptr<=(owner+1) mod NUM_IN.
    - in_req is ignored while BUSY.
- Output register:
  - Consumed when out_valid & out_ready.
  - If no new flit is loaded in the same cycle, out_valid<=0.
  - Simultaneous consume and load is allowed and gives full throughput: 1 flit/cycle.
  - Flit data holds stable while out_valid=1 and out_ready=0.
- Release timing:
  - occupied[0] drops the cycle after the tail enters the output register; the tail may still be pending downstream.
  - At least one IDLE cycle separates packets, so there is no grant in the release cycle.
- Simultaneous events:
  - Multiple requesters: round-robin order above decides.
  - Requests from inputs other than the owner while BUSY are not queued; they are re-evaluated in IDLE.
- rr_ptr wraps: owner NUM_IN-1 gives rr_ptr 0.
- Width rules:
  - owner is a 3-bit value; unused high ids are unreachable.
  - occupied[1:3] holds the owner value even at the IDLE reset value 0; consumers gate with occupied[0].
- in_valid[owner]=0 in BUSY: no transfer, remain BUSY; bubbles allowed.

Test Plan:
- Reset then single requester: in_req=5'b00100 -> next cycle occupied=4'b1010; 3-flit packet (tail on the 3rd) with out_ready=1 streams out on consecutive cycles; occupied=0 the cycle after the tail is loaded; rr_ptr=3.
- Contention with rr_ptr=0: in_req=5'b10010 -> input 1 wins (occupied=4'b1001); after its tail, input 4 still requesting wins (occupied=4'b1100); after that tail, rr_ptr=0.
- Backpressure: hold out_ready=0 with out_valid=1 -> in_ready[owner]=0 and out_flit stable for 4 cycles; raise out_ready -> one flit per cycle resumes, no loss or duplication.
- Single-flit packet: in_valid=in_tail=1 from input 2 -> one flit out, occupied busy for exactly 1 cycle, then IDLE.
- Non-owner isolation: owner=0 while input 3 asserts in_valid/in_req -> in_ready[3]=0 throughout; no input-3 data on out_flit.
- Mid-packet reset: assert rst_n=0 after the 2nd of 4 flits -> next cycle occupied=0, out_valid=0, rr_ptr=0; a new request is granted normally afterwards.
